// File: rtl/uart_pkg.sv
// Shared UART receive constants: rx FSM state encoding, bit-period derivation
// and the number of bytes packed into one instruction word.
package uart_pkg;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam int BYTES_PER_INSTR = 4;

  // Integer-truncated bit period in system clocks.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  localparam int CLKS_PER_BIT_DEF = clks_per_bit(12000000, 115200);

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop rx synchroniser, start/data/stop FSM and baud counter.
// With INSTR_TIMEOUT_EN defined an extra busy output reports FSM != IDLE.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk12,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
`ifdef INSTR_TIMEOUT_EN
  ,
  output logic       busy
`endif
);

  localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);

  logic        rx_s1, rx_s2, rx_prev;
  logic [1:0]  state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        take_bit;
  logic        stop_good;

  // Synchroniser; rx_prev gives the 1->0 edge so a line held low after a
  // framing error cannot re-arm until it has returned high.
  always_ff @(posedge clk12 or negedge rstn) begin
    if (!rstn) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign take_bit  = (state == RX_DATA) && (cnt == BIT_END);
  assign stop_good = (state == RX_STOP) && (cnt == BIT_END) && rx_s2;

  always_ff @(posedge clk12 or negedge rstn) begin
    if (!rstn) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (rx_prev && !rx_s2) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_END) begin
            cnt   <= '0;
            state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_END) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          if (cnt == BIT_END) begin
            cnt       <= '0;
            state     <= RX_IDLE;
            valid     <= rx_s2;
            frame_err <= !rx_s2;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // Datapath registers carry no reset; valid qualifies them.
  always_ff @(posedge clk12) begin
    if (take_bit)  shreg <= {rx_s2, shreg[7:1]};
    if (stop_good) data  <= shreg;
  end

`ifdef INSTR_TIMEOUT_EN
  assign busy = (state != RX_IDLE);
`endif

endmodule

// File: rtl/uart_instr_assembler.sv
// Packs four little-endian UART bytes into a 32-bit instruction with a 1-cycle strobe.
// Optional INSTR_TIMEOUT_EN discards a partial word after TIMEOUT_CLKS idle clocks.
module uart_instr_assembler
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200
`ifdef INSTR_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CLKS = 120000
`endif
) (
  input  logic        clk12,
  input  logic        rstn,
  input  logic        rx,
  output logic [31:0] instruction,
  output logic        instruction_rcv,
  output logic        frame_err,
  output logic [1:0]  byte_count
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_INSTR - 1);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic [7:0] lanes [3];

`ifdef INSTR_TIMEOUT_EN
  logic        rx_busy;
  logic [31:0] idle_cnt;
  logic        timeout_hit;
`endif

  uart_rx_byte #(
    .CLKS_PER_BIT(clks_per_bit(CLK_HZ, BAUD))
  ) u_rx (
    .clk12    (clk12),
    .rstn     (rstn),
    .rx       (rx),
    .data     (rx_data),
    .valid    (rx_valid),
    .frame_err(rx_frame_err)
`ifdef INSTR_TIMEOUT_EN
    ,
    .busy     (rx_busy)
`endif
  );

  assign frame_err = rx_frame_err;

`ifdef INSTR_TIMEOUT_EN
  // Idle clocks with a partial word pending; any start bit restarts the count.
  always_ff @(posedge clk12 or negedge rstn) begin
    if (!rstn) begin
      idle_cnt <= '0;
    end else if (rx_busy || byte_count == 2'd0) begin
      idle_cnt <= '0;
    end else if (!timeout_hit) begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end

  assign timeout_hit = (idle_cnt == 32'(TIMEOUT_CLKS));
`endif

  always_ff @(posedge clk12 or negedge rstn) begin
    if (!rstn) begin
      instruction     <= '0;
      instruction_rcv <= 1'b0;
      byte_count      <= '0;
    end else begin
      instruction_rcv <= 1'b0;
      if (rx_frame_err) begin
        byte_count <= '0;
      end else if (rx_valid) begin
        if (byte_count == LAST_LANE) begin
          instruction     <= {rx_data, lanes[2], lanes[1], lanes[0]};
          instruction_rcv <= 1'b1;
          byte_count      <= '0;
        end else begin
          byte_count <= byte_count + 2'd1;
        end
      end
`ifdef INSTR_TIMEOUT_EN
      else if (timeout_hit) begin
        byte_count <= '0;
      end
`endif
    end
  end

  // Lanes are only read behind byte_count, so stale contents are harmless.
  always_ff @(posedge clk12) begin
    if (rx_valid && byte_count != LAST_LANE) lanes[byte_count] <= rx_data;
  end

endmodule

// File: tb/tb_uart_instr_assembler.sv
// Randomised self-checking bench for uart_instr_assembler with a byte-queue reference model.
module tb_uart_instr_assembler;

  localparam int CPB        = 12000000 / 115200;
  localparam int TB_TIMEOUT = 3000;

  logic        clk12;
  logic        rstn;
  logic        rx;
  logic [31:0] instruction;
  logic        instruction_rcv;
  logic        frame_err;
  logic [1:0]  byte_count;

  int tests_run = 0;
  int fails     = 0;

  logic [7:0]  mq[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] prev_instr;
  int          unstable_cnt = 0;
  int          ferr_cnt     = 0;

  uart_instr_assembler #(
    .CLK_HZ(12000000),
    .BAUD  (115200)
`ifdef INSTR_TIMEOUT_EN
    ,
    .TIMEOUT_CLKS(TB_TIMEOUT)
`endif
  ) dut (
    .clk12          (clk12),
    .rstn           (rstn),
    .rx             (rx),
    .instruction    (instruction),
    .instruction_rcv(instruction_rcv),
    .frame_err      (frame_err),
    .byte_count     (byte_count)
  );

  initial clk12 = 1'b0;
  always #5 clk12 = ~clk12;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk12) begin
    if (!rstn) begin
      prev_instr = '0;
    end else begin
      if (instruction_rcv) got_q.push_back(instruction);
      else if (instruction !== prev_instr) unstable_cnt++;
      if (frame_err) ferr_cnt++;
      prev_instr = instruction;
    end
  end

  task automatic model_byte(input logic [7:0] b, input logic ok);
    if (!ok) begin
      mq.delete();
    end else begin
      mq.push_back(b);
      if (mq.size() == 4) begin
        exp_q.push_back({mq[3], mq[2], mq[1], mq[0]});
        mq.delete();
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    repeat (CPB) @(posedge clk12);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk12);
    end
    rx = stop_ok;
    repeat (CPB) @(posedge clk12);
    rx = 1'b1;
    if (!stop_ok) repeat (CPB) @(posedge clk12);
    model_byte(b, stop_ok);
    repeat (2) @(posedge clk12);
  endtask

  task automatic flush_queues();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    rx   = 1'b1;
    repeat (5) @(posedge clk12);
    #1;
    tests_run++;
    if (instruction !== 32'h0 || instruction_rcv !== 1'b0 || frame_err !== 1'b0 || byte_count !== 2'd0) begin
      fails++;
      $display("FAIL reset_outputs: got instr=%h rcv=%b ferr=%b cnt=%0d, want all zero",
               instruction, instruction_rcv, frame_err, byte_count);
    end
    @(negedge clk12);
    rstn = 1'b1;
    repeat (20) @(posedge clk12);
    #1;
    tests_run++;
    if (instruction !== 32'h0 || byte_count !== 2'd0 || got_q.size() != 0) begin
      fails++;
      $display("FAIL reset_idle: got instr=%h cnt=%0d strobes=%0d, want 0/0/0",
               instruction, byte_count, got_q.size());
    end
    mq.delete();
    flush_queues();
  endtask

  task automatic test_single_word();
    flush_queues();
    send_byte(8'h13, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    tests_run++;
    if (got_q.size() != 1 || got_q[0] !== 32'h00000013) begin
      fails++;
      $display("FAIL single_word: strobes=%0d first=%h, want 1 x 00000013",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'h0);
    end
    tests_run++;
    if (byte_count !== 2'd0) begin
      fails++;
      $display("FAIL single_word_count: got %0d want 0", byte_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [8];
    seq = '{8'h93, 8'h00, 8'h50, 8'h00, 8'hB3, 8'h81, 8'h20, 8'h00};
    flush_queues();
    unstable_cnt = 0;
    for (int i = 0; i < 8; i++) send_byte(seq[i], 1'b1);
    tests_run++;
    if (got_q.size() != 2) begin
      fails++;
      $display("FAIL b2b_count: got %0d strobes want 2", got_q.size());
    end else begin
      tests_run++;
      if (got_q[0] !== 32'h00500093) begin
        fails++;
        $display("FAIL b2b_word0: got %h want 00500093", got_q[0]);
      end
      tests_run++;
      if (got_q[1] !== 32'h002081B3) begin
        fails++;
        $display("FAIL b2b_word1: got %h want 002081B3", got_q[1]);
      end
    end
    tests_run++;
    if (unstable_cnt != 0 || instruction !== 32'h002081B3) begin
      fails++;
      $display("FAIL b2b_stable: changes_without_strobe=%0d instr=%h, want 0 / 002081B3",
               unstable_cnt, instruction);
    end
  endtask

  task automatic test_glitch();
    int ferr0;
    flush_queues();
    send_byte(8'h55, 1'b1);
    ferr0 = ferr_cnt;
    rx = 1'b0;
    repeat (20) @(posedge clk12);
    rx = 1'b1;
    repeat (300) @(posedge clk12);
    #1;
    tests_run++;
    if (got_q.size() != 0 || ferr_cnt != ferr0) begin
      fails++;
      $display("FAIL glitch_reject: strobes=%0d frame_errs=%0d, want 0/0",
               got_q.size(), ferr_cnt - ferr0);
    end
    tests_run++;
    if (byte_count !== 2'(mq.size())) begin
      fails++;
      $display("FAIL glitch_count: got %0d want %0d", byte_count, mq.size());
    end
  endtask

  task automatic test_frame_err();
    int ferr0;
    flush_queues();
    ferr0 = ferr_cnt;
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b0);
    tests_run++;
    if (ferr_cnt - ferr0 != 1 || byte_count !== 2'd0 || got_q.size() != 0) begin
      fails++;
      $display("FAIL frame_err: pulses=%0d cnt=%0d strobes=%0d, want 1/0/0",
               ferr_cnt - ferr0, byte_count, got_q.size());
    end
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    tests_run++;
    if (got_q.size() != 1 || got_q[0] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL frame_resync: strobes=%0d first=%h, want 1 x DEADBEEF",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'h0);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] partial;
    flush_queues();
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    partial = 8'($urandom);
    rx = 1'b0;
    repeat (CPB) @(posedge clk12);
    for (int i = 0; i < 4; i++) begin
      rx = partial[i];
      repeat (CPB) @(posedge clk12);
    end
    #2;
    rstn = 1'b0;
    #1;
    tests_run++;
    if (instruction !== 32'h0 || byte_count !== 2'd0 || instruction_rcv !== 1'b0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: instr=%h cnt=%0d rcv=%b ferr=%b, want all zero",
               instruction, byte_count, instruction_rcv, frame_err);
    end
    rx = 1'b1;
    repeat (5) @(posedge clk12);
    @(negedge clk12);
    rstn = 1'b1;
    mq.delete();
    repeat (20) @(posedge clk12);
    flush_queues();
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    tests_run++;
    if (got_q.size() != 1 || got_q[0] !== 32'h04030201) begin
      fails++;
      $display("FAIL reset_fresh_word: strobes=%0d first=%h, want 1 x 04030201",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'h0);
    end
  endtask

  task automatic test_timeout();
    logic [7:0]  s0, s1, s2;
    logic [31:0] want;
    logic [1:0]  want_cnt;
    flush_queues();
    s0 = 8'($urandom);
    s1 = 8'($urandom);
    s2 = 8'($urandom);
    send_byte(s0, 1'b1);
    send_byte(s1, 1'b1);
    send_byte(s2, 1'b1);
    repeat (TB_TIMEOUT + 1) @(posedge clk12);
`ifdef INSTR_TIMEOUT_EN
    mq.delete();
    want     = 32'h00000013;
    want_cnt = 2'd0;
`else
    want     = {8'h13, s2, s1, s0};
    want_cnt = 2'd3;
`endif
    send_byte(8'h13, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    tests_run++;
    if (got_q.size() != 1 || got_q[0] !== want) begin
      fails++;
      $display("FAIL timeout_word: strobes=%0d first=%h, want 1 x %h",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'h0, want);
    end
    tests_run++;
    if (byte_count !== want_cnt) begin
      fails++;
      $display("FAIL timeout_count: got %0d want %0d", byte_count, want_cnt);
    end
  endtask

  task automatic test_random();
    int ferr0, ferr_exp;
    flush_queues();
    unstable_cnt = 0;
    ferr0    = ferr_cnt;
    ferr_exp = 0;
    for (int n = 0; n < 22; n++) begin
      logic ok;
      ok = ($urandom_range(0, 6) != 0);
      if (!ok) ferr_exp++;
      send_byte(8'($urandom), ok);
      repeat ($urandom_range(0, 40)) @(posedge clk12);
    end
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL random_strobes: got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL random_word%0d: got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    tests_run++;
    if (byte_count !== 2'(mq.size()) || ferr_cnt - ferr0 != ferr_exp || unstable_cnt != 0) begin
      fails++;
      $display("FAIL random_state: cnt=%0d/%0d frame_errs=%0d/%0d unstable=%0d",
               byte_count, mq.size(), ferr_cnt - ferr0, ferr_exp, unstable_cnt);
    end
  endtask

  initial begin
    rx   = 1'b1;
    rstn = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_word();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
